// File: rtl/sky_writeback_arbiter_if.sv
// Bundle of pipeline, late-result and register-file signals around the writeback arbiter.
// master = producer/consumer side (pipeline, long-latency units, RF); slave = the arbiter.
interface sky_writeback_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 4,
    parameter int LATE_DEPTH = 4
);
    localparam int CNT_W = $clog2(LATE_DEPTH + 1);

    logic [XLEN-1:0]       result_in;
    logic [XLEN-1:0]       mem_data;
    logic [1:0]            mem_size;
    logic                  mem_unsigned;
    logic [1:0]            mem_offset;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic                  wb_reg_write;
    logic                  wb_from_mem;
    logic                  late_valid;
    logic                  late_ready;
    logic [REG_ADDR_W-1:0] late_rd_addr;
    logic [XLEN-1:0]       late_data;
    logic                  rf_write_enable;
    logic [REG_ADDR_W-1:0] rf_write_addr;
    logic [XLEN-1:0]       rf_write_data;
    logic [CNT_W-1:0]      late_count;
    logic                  late_pending;

    modport master (
        output result_in, mem_data, mem_size, mem_unsigned, mem_offset,
               wb_rd_addr, wb_reg_write, wb_from_mem,
               late_valid, late_rd_addr, late_data,
        input  late_ready, rf_write_enable, rf_write_addr, rf_write_data,
               late_count, late_pending
    );

    modport slave (
        input  result_in, mem_data, mem_size, mem_unsigned, mem_offset,
               wb_rd_addr, wb_reg_write, wb_from_mem,
               late_valid, late_rd_addr, late_data,
        output late_ready, rf_write_enable, rf_write_addr, rf_write_data,
               late_count, late_pending
    );
endinterface

// File: rtl/sky_writeback_arbiter.sv
// Writeback arbiter: pipeline results own the RF port; late results queue in a FIFO and drain when idle.
// Optional macro SKY_WB_LOAD_ALIGN_EN enables byte/half load extraction with sign/zero extension.
module sky_writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 4,
    parameter int LATE_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    sky_writeback_arbiter_if.slave   wb
);
    localparam int PTR_W = $clog2(LATE_DEPTH);
    localparam int CNT_W = $clog2(LATE_DEPTH + 1);

    logic [LATE_DEPTH-1:0] fifo_live;
    logic [REG_ADDR_W-1:0] fifo_rd   [LATE_DEPTH];
    logic [XLEN-1:0]       fifo_data [LATE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count, count_next;
    logic                  full, push, pop, pending_q;
    logic [XLEN-1:0]       load_data;

    always_comb begin
        load_data = wb.mem_data;
`ifdef SKY_WB_LOAD_ALIGN_EN
        case (wb.mem_size)
            2'b00: load_data = {{(XLEN-8){~wb.mem_unsigned & wb.mem_data[{wb.mem_offset, 3'b111}]}},
                                wb.mem_data[{wb.mem_offset, 3'b000} +: 8]};
            2'b01: load_data = {{(XLEN-16){~wb.mem_unsigned & wb.mem_data[{wb.mem_offset[1], 4'b1111}]}},
                                wb.mem_data[{wb.mem_offset[1], 4'b0000} +: 16]};
            default: load_data = wb.mem_data;
        endcase
`endif
    end

`ifndef SKY_WB_LOAD_ALIGN_EN
    logic unused_load_ctrl;
    assign unused_load_ctrl = ^{wb.mem_size, wb.mem_unsigned, wb.mem_offset};
`endif

    // A full FIFO refuses pushes even while popping, so there is never a pass-through path.
    assign full  = (count == CNT_W'(LATE_DEPTH));
    assign push  = wb.late_valid && !full;
    assign pop   = !wb.wb_reg_write && (count != '0);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    assign wb.late_ready   = !full;
    assign wb.late_count   = count;
    assign wb.late_pending = pending_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= wb.late_rd_addr;
            fifo_data[wr_ptr] <= wb.late_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_live          <= '0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            pending_q          <= 1'b0;
            wb.rf_write_enable <= 1'b0;
            wb.rf_write_addr   <= '0;
            wb.rf_write_data   <= '0;
        end else begin
            // A younger pipeline write makes any queued result for the same register stale.
            for (int i = 0; i < LATE_DEPTH; i++) begin
                if (wb.wb_reg_write && fifo_rd[i] == wb.wb_rd_addr)
                    fifo_live[i] <= 1'b0;
            end
            if (push) begin
                fifo_live[wr_ptr] <= !(wb.wb_reg_write && wb.late_rd_addr == wb.wb_rd_addr);
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            pending_q <= (count_next != '0);

            if (wb.wb_reg_write) begin
                wb.rf_write_enable <= 1'b1;
                wb.rf_write_addr   <= wb.wb_rd_addr;
                wb.rf_write_data   <= wb.wb_from_mem ? load_data : wb.result_in;
            end else if (pop && fifo_live[rd_ptr]) begin
                wb.rf_write_enable <= 1'b1;
                wb.rf_write_addr   <= fifo_rd[rd_ptr];
                wb.rf_write_data   <= fifo_data[rd_ptr];
            end else begin
                wb.rf_write_enable <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sky_writeback_arbiter.sv
// Bench for sky_writeback_arbiter: scenario tasks plus a scoreboard of expected RF writes.
// Load-alignment cases follow SKY_WB_LOAD_ALIGN_EN the same way the design does.
module tb_sky_writeback_arbiter;
    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    wr_t  exp_q[$];

    sky_writeback_arbiter_if #(.XLEN(32), .REG_ADDR_W(4), .LATE_DEPTH(4)) bus ();

    sky_writeback_arbiter #(.XLEN(32), .REG_ADDR_W(4), .LATE_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] timeout");
    end

    // Every RF write must match the next expected write, in order.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (bus.rf_write_enable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: write addr=%0d data=%h, required no write",
                         bus.rf_write_addr, bus.rf_write_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.rf_write_addr !== e.addr || bus.rf_write_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             bus.rf_write_addr, bus.rf_write_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic set_idle();
        bus.result_in    = '0;
        bus.mem_data     = '0;
        bus.mem_size     = 2'b10;
        bus.mem_unsigned = 1'b0;
        bus.mem_offset   = 2'b00;
        bus.wb_rd_addr   = '0;
        bus.wb_reg_write = 1'b0;
        bus.wb_from_mem  = 1'b0;
        bus.late_valid   = 1'b0;
        bus.late_rd_addr = '0;
        bus.late_data    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_write(input logic [3:0] rd, input logic [31:0] data);
        bus.wb_reg_write = 1'b1;
        bus.wb_from_mem  = 1'b0;
        bus.wb_rd_addr   = rd;
        bus.result_in    = data;
        exp_q.push_back('{rd, data});
    endtask

    task automatic late_offer(input logic [3:0] rd, input logic [31:0] data);
        bus.late_valid   = 1'b1;
        bus.late_rd_addr = rd;
        bus.late_data    = data;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.rf_write_enable !== 1'b0 || bus.rf_write_addr !== 4'd0 || bus.rf_write_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rf: got en=%b addr=%0d data=%h, required 0/0/0",
                     bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data);
        end
        checks++;
        if (bus.late_count !== 3'd0 || bus.late_pending !== 1'b0 || bus.late_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: got count=%0d pending=%b ready=%b, required 0/0/1",
                     bus.late_count, bus.late_pending, bus.late_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got en=%b, required 0", bus.rf_write_enable);
        end
    endtask

    task automatic test_pipeline_write();
        @(negedge clk);
        pipe_write(4'd3, 32'h0000_1234);
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b1) begin
            errors++;
            $display("FAIL pipe_latency: got en=%b, required 1", bus.rf_write_enable);
        end
        @(negedge clk);
        set_idle();
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b0 || bus.rf_write_addr !== 4'd3 || bus.rf_write_data !== 32'h1234) begin
            errors++;
            $display("FAIL pipe_hold: got en=%b addr=%0d data=%h, required 0/3/00001234",
                     bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data);
        end
    endtask

    task automatic test_load_align();
        logic [1:0]  size [4];
        logic        uns  [4];
        logic [1:0]  off  [4];
        logic [31:0] want [4];
`ifdef SKY_WB_LOAD_ALIGN_EN
        size = '{2'b00, 2'b01, 2'b00, 2'b01};
        uns  = '{1'b0, 1'b1, 1'b0, 1'b0};
        off  = '{2'd3, 2'd2, 2'd2, 2'd1};
        want = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_FFFF, 32'h0000_7F01};
`else
        size = '{2'b00, 2'b01, 2'b00, 2'b11};
        uns  = '{1'b0, 1'b1, 1'b1, 1'b0};
        off  = '{2'd3, 2'd2, 2'd1, 2'd0};
        want = '{32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_idle();
            bus.wb_reg_write = 1'b1;
            bus.wb_from_mem  = 1'b1;
            bus.wb_rd_addr   = 4'd4 + 4'(i);
            bus.result_in    = 32'hDEAD_BEEF;
            bus.mem_data     = 32'h80FF_7F01;
            bus.mem_size     = size[i];
            bus.mem_unsigned = uns[i];
            bus.mem_offset   = off[i];
            exp_q.push_back('{4'd4 + 4'(i), want[i]});
            tick();
            checks++;
            if (bus.rf_write_enable !== 1'b1) begin
                errors++;
                $display("FAIL load_en[%0d]: got en=%b, required 1", i, bus.rf_write_enable);
            end
        end
        @(negedge clk);
        set_idle();
        tick();
    endtask

    task automatic test_late_drain();
        @(negedge clk);
        late_offer(4'd5, 32'h0000_00AA);
        exp_q.push_back('{4'd5, 32'h0000_00AA});
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b0 || bus.late_count !== 3'd1 || bus.late_pending !== 1'b1) begin
            errors++;
            $display("FAIL late_enqueue: got en=%b count=%0d pending=%b, required 0/1/1",
                     bus.rf_write_enable, bus.late_count, bus.late_pending);
        end
        @(negedge clk);
        set_idle();
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b1 || bus.late_count !== 3'd0) begin
            errors++;
            $display("FAIL late_drain: got en=%b count=%0d, required 1/0",
                     bus.rf_write_enable, bus.late_count);
        end
        // Same push, but the pipeline keeps the port busy for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_idle();
            pipe_write(4'd1 + 4'(i), 32'h0000_0300 + 32'(i));
            if (i == 0) late_offer(4'd6, 32'h0000_00BB);
            tick();
        end
        exp_q.push_back('{4'd6, 32'h0000_00BB});
        checks++;
        if (bus.late_count !== 3'd1) begin
            errors++;
            $display("FAIL late_wait: got count=%0d, required 1", bus.late_count);
        end
        @(negedge clk);
        set_idle();
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b1 || bus.rf_write_addr !== 4'd6 || bus.late_count !== 3'd0) begin
            errors++;
            $display("FAIL late_delayed: got en=%b addr=%0d count=%0d, required 1/6/0",
                     bus.rf_write_enable, bus.rf_write_addr, bus.late_count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_idle();
            pipe_write(4'd12, 32'h0000_0200 + 32'(i));
            if (i < 4) late_offer(4'd8 + 4'(i), 32'h0000_0100 + 32'(i));
            else       late_offer(4'd13, 32'h0000_DEAD);
            tick();
            if (i >= 3) begin
                checks++;
                if (bus.late_count !== 3'd4 || bus.late_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_state[%0d]: got count=%0d ready=%b, required 4/0",
                             i, bus.late_count, bus.late_ready);
                end
            end
        end
        for (int i = 0; i < 4; i++) exp_q.push_back('{4'd8 + 4'(i), 32'h0000_0100 + 32'(i)});
        // First drain cycle still offers a result; a full FIFO must not take it.
        @(negedge clk);
        bus.wb_reg_write = 1'b0;
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b1 || bus.late_count !== 3'd3 || bus.late_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_first_pop: got en=%b count=%0d ready=%b, required 1/3/1",
                     bus.rf_write_enable, bus.late_count, bus.late_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_idle();
            tick();
            checks++;
            if (bus.rf_write_enable !== 1'b1 || bus.late_count !== 3'(2 - i)) begin
                errors++;
                $display("FAIL full_drain[%0d]: got en=%b count=%0d, required 1/%0d",
                         i, bus.rf_write_enable, bus.late_count, 2 - i);
            end
        end
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b0 || bus.late_pending !== 1'b0) begin
            errors++;
            $display("FAIL full_empty: got en=%b pending=%b, required 0/0",
                     bus.rf_write_enable, bus.late_pending);
        end
    endtask

    task automatic test_kill();
        @(negedge clk);
        set_idle();
        late_offer(4'd7, 32'h0000_0011);
        tick();
        @(negedge clk);
        set_idle();
        pipe_write(4'd7, 32'h0000_0022);
        tick();
        @(negedge clk);
        set_idle();
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b0 || bus.late_count !== 3'd0 || bus.rf_write_data !== 32'h22) begin
            errors++;
            $display("FAIL kill_next: got en=%b count=%0d data=%h, required 0/0/00000022",
                     bus.rf_write_enable, bus.late_count, bus.rf_write_data);
        end
        // Kill of an entry pushed in the very cycle of the pipeline write.
        @(negedge clk);
        pipe_write(4'd9, 32'h0000_0099);
        late_offer(4'd9, 32'h0000_0055);
        tick();
        checks++;
        if (bus.late_count !== 3'd1) begin
            errors++;
            $display("FAIL kill_same_push: got count=%0d, required 1", bus.late_count);
        end
        @(negedge clk);
        set_idle();
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b0 || bus.late_count !== 3'd0) begin
            errors++;
            $display("FAIL kill_same_pop: got en=%b count=%0d, required 0/0",
                     bus.rf_write_enable, bus.late_count);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_idle();
        late_offer(4'd2, 32'h0000_00C1);
        exp_q.push_back('{4'd2, 32'h0000_00C1});
        tick();
        @(negedge clk);
        late_offer(4'd3, 32'h0000_00C2);
        exp_q.push_back('{4'd3, 32'h0000_00C2});
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b1 || bus.late_count !== 3'd1) begin
            errors++;
            $display("FAIL b2b_push_pop: got en=%b count=%0d, required 1/1",
                     bus.rf_write_enable, bus.late_count);
        end
        @(negedge clk);
        set_idle();
        tick();
        checks++;
        if (bus.rf_write_enable !== 1'b1 || bus.late_count !== 3'd0) begin
            errors++;
            $display("FAIL b2b_last: got en=%b count=%0d, required 1/0",
                     bus.rf_write_enable, bus.late_count);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_idle();
            pipe_write(4'd1 + 4'(i), 32'h0000_0400 + 32'(i));
            late_offer(4'd10 + 4'(i), 32'h0000_0500 + 32'(i));
            tick();
        end
        @(negedge clk);
        set_idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rf_write_enable !== 1'b0 || bus.late_count !== 3'd0 || bus.late_pending !== 1'b0
            || bus.late_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got en=%b count=%0d pending=%b ready=%b, required 0/0/0/1",
                     bus.rf_write_enable, bus.late_count, bus.late_pending, bus.late_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (bus.late_count !== 3'd0 || bus.rf_write_addr !== 4'd0) begin
            errors++;
            $display("FAIL async_after: got count=%0d addr=%0d, required 0/0",
                     bus.late_count, bus.rf_write_addr);
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_pipeline_write();
        test_load_align();
        test_late_drain();
        test_full();
        test_kill();
        test_back_to_back();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected writes, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sky_writeback_arbiter.md
# sky_writeback_arbiter

Writeback stage for the execution pipeline. It merges two result sources onto the single register-file write port: the in-order pipeline result (ALU or load) and out-of-order results from long-latency units such as mul/div. Late results are buffered in a small FIFO and drained into idle writeback slots. Stale late results, ones overwritten by a younger pipeline write to the same register, are discarded. It sits between the memory stage and the register file, and replaces the purely combinational writeback mux.

## Interface
Parameters:
- XLEN, 32, datapath width
- REG_ADDR_W, 4, register address width
- LATE_DEPTH, 4, late-result FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- result_in  in  XLEN  ALU result from memory stage
- mem_data  in  XLEN  raw load word from data memory
- mem_size  in  2  load size: 00 byte, 01 half, 10 word
- mem_unsigned  in  1  zero-extend narrow loads
- mem_offset  in  2  load byte address [1:0]
- wb_rd_addr  in  REG_ADDR_W  pipeline destination register
- wb_reg_write  in  1  pipeline write request
- wb_from_mem  in  1  select load data instead of result_in
- late_valid  in  1  late result offered
- late_ready  out  1  FIFO can accept; equals !full
- late_rd_addr  in  REG_ADDR_W  late destination register
- late_data  in  XLEN  late result
- rf_write_enable  out  1  registered RF write strobe
- rf_write_addr  out  REG_ADDR_W  registered RF write address
- rf_write_data  out  XLEN  registered RF write data
- late_count  out  $clog2(LATE_DEPTH+1)  FIFO occupancy
- late_pending  out  1  occupancy ≠ 0

## Operation
- Pipeline priority. When wb_reg_write=1, the pipeline owns the port this cycle. Data is the aligned load if wb_from_mem=1, else result_in.
- Late enqueue. A late result is pushed when late_valid && late_ready. Each FIFO entry holds {live, rd, data}, and live=1 on push.
- Drain. When wb_reg_write=0 and the FIFO is non-empty, the head is popped.
  - If the head is live, it drives the RF write.
  - If the head is dead, it is popped with no write.
- Kill. Every pipeline write clears live on all FIFO entries with a matching rd. This includes an entry being pushed in the same cycle. Issue logic guarantees that pipeline writes are younger than all outstanding late results.
- Simultaneous push and pop are allowed in one cycle. Occupancy is unchanged, and pointers wrap modulo LATE_DEPTH.
- When full, late_ready=0 even if a pop occurs in the same cycle. There is no pass-through.
- Load alignment (when enabled):
  - byte = mem_data >> (8*mem_offset), bits [7:0]
  - half = mem_data >> (16*mem_offset[1]), bits [15:0]; mem_offset[0] is ignored
  - narrow loads are sign-extended unless mem_unsigned=1
  - mem_size=11 is treated as word

## Timing
- Reset, asynchronous: all state clears immediately.
  - rf_write_enable=0, rf_write_addr=0, rf_write_data=0
  - FIFO emptied, late_count=0, late_pending=0, late_ready=1
  - In-flight late results are lost.
- Pipeline latency: request in cycle N → rf_write_* valid in cycle N+1.
- Late latency: handshake in cycle N → entry visible in cycle N+1 → RF write in cycle N+2 if the port is idle in N+1. Otherwise it waits.
- rf_write_enable is high for exactly one cycle per write. rf_write_addr and rf_write_data hold their last values when it is low.
- late_count and late_pending are registered and reflect pushes and pops from the prior edge.

## Configuration
- SKY_WB_LOAD_ALIGN_EN defined: load path performs byte/half extraction and sign/zero extension per mem_size, mem_offset and mem_unsigned.
- Not defined: load data = mem_data unmodified. mem_size, mem_unsigned and mem_offset are ignored.

## Test plan
- Pipeline write: wb_reg_write=1, rd=3, result_in=0x1234 → cycle+1: enable=1, addr=3, data=0x1234.
- Load align (macro on): mem_data=0x80FF7F01, byte, offset=3, signed → 0xFFFFFF80; half, offset=2, unsigned → 0x000080FF.
- Late drain: push {rd=5, 0xAA} with pipeline idle → RF write rd=5, data=0xAA two cycles after the handshake. With pipeline busy for 3 cycles, the write is delayed until the first idle cycle.
- Full/backpressure: push 4 entries while the pipeline writes every cycle → late_ready=0, late_count=4. After the pipeline goes idle, entries drain in order, one per cycle, and late_ready returns to 1 after the first pop.
- Kill: push {rd=7, 0x11}, then in the next cycle pipeline writes rd=7 with 0x22 → only 0x22 is written to rd 7. The dead entry pops with no write and late_count returns to 0.
- Async reset mid-drain: rst_n low with 3 entries queued → rf_write_enable=0 and late_count=0 immediately. No writes occur after release.
